// File: rtl/boot_pkg.sv
// Shared types and constants for the boot loader: FSM states, default frame
// start word and the header field positions.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE, HDR, IMEM, DMEM_LO, DMEM_HI, CSUM, RUN, ERROR
  } state_t;

  localparam logic [31:0] MAGIC_DEFAULT = 32'hB007_10AD;

  localparam int ICOUNT_HI = 31;
  localparam int ICOUNT_LO = 16;
  localparam int DCOUNT_HI = 15;
  localparam int DCOUNT_LO = 0;

endpackage

// File: rtl/boot_loader_if.sv
// Host word stream plus the instruction/data memory write ports of the loader.
interface boot_loader_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [63:0] imem_addr;
  logic        imem_wen;
  logic [31:0] imem_wdata;
  logic [63:0] dmem_addr;
  logic        dmem_wen;
  logic [63:0] dmem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, imem_addr, imem_wen, imem_wdata, dmem_addr, dmem_wen, dmem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_addr, imem_wen, imem_wdata, dmem_addr, dmem_wen, dmem_wdata
  );
endinterface

// File: rtl/boot_csum.sv
// XOR accumulator for the frame checksum; clear wins over enable.
module boot_csum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (en)    q <= q ^ din;
  end
endmodule

// File: rtl/boot_loader.sv
// Frame-driven program loader: writes instruction and data words into the
// cpu memories, verifies the XOR checksum, then enables the cpu.
module boot_loader
  import boot_pkg::*;
#(
  parameter int          IMEM_DEPTH = 512,
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [31:0] MAGIC      = MAGIC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  boot_loader_if.slave bus,
  output logic         cpu_enable,
  output logic         busy,
  output logic         error
);
  localparam int IW = $clog2(IMEM_DEPTH) + 1;
  localparam int DW = $clog2(DMEM_DEPTH) + 1;

  state_t        state, nxt;
  logic [IW-1:0] icnt, i;
  logic [DW-1:0] dcnt, j;
  logic [31:0]   lo, csum;
  logic [15:0]   hdr_i, hdr_d;
  logic          fire, hdr_bad, i_last, j_last, csum_clr, csum_en;

  assign fire    = bus.s_valid & bus.s_ready;
  assign hdr_i   = bus.s_data[ICOUNT_HI:ICOUNT_LO];
  assign hdr_d   = bus.s_data[DCOUNT_HI:DCOUNT_LO];
  assign hdr_bad = (int'(hdr_i) > IMEM_DEPTH) || (int'(hdr_d) > DMEM_DEPTH);
  assign i_last  = (i + IW'(1)) == icnt;
  assign j_last  = (j + DW'(1)) == dcnt;

  // IDLE keeps the accumulator at zero so the header beat loads it directly.
  assign csum_clr = (state == IDLE);
  assign csum_en  = fire && (state inside {HDR, IMEM, DMEM_LO, DMEM_HI});

  boot_csum u_csum (
    .clk (clk),
    .rst (rst),
    .clr (csum_clr),
    .en  (csum_en),
    .din (bus.s_data),
    .q   (csum)
  );

  always_comb begin
    nxt = state;
    if (fire) begin
      unique case (state)
        IDLE:    if (bus.s_data == MAGIC) nxt = HDR;
        HDR: begin
          if (hdr_bad)         nxt = ERROR;
          else if (hdr_i != 0) nxt = IMEM;
          else if (hdr_d != 0) nxt = DMEM_LO;
          else                 nxt = CSUM;
        end
        IMEM:    if (i_last) nxt = (dcnt != 0) ? DMEM_LO : CSUM;
        DMEM_LO: nxt = DMEM_HI;
        DMEM_HI: nxt = j_last ? CSUM : DMEM_LO;
        CSUM:    nxt = (bus.s_data == csum) ? RUN : ERROR;
        default: nxt = state;
      endcase
    end
  end

  // Status outputs are decoded from the next state so they land in the
  // cycle right after the beat that caused the transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.s_ready    <= 1'b1;
      busy           <= 1'b0;
      cpu_enable     <= 1'b0;
      error          <= 1'b0;
      bus.imem_wen   <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.dmem_wen   <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      icnt           <= '0;
      dcnt           <= '0;
      i              <= '0;
      j              <= '0;
      lo             <= '0;
    end else begin
      state        <= nxt;
      bus.s_ready  <= !(nxt inside {RUN, ERROR});
      busy         <= nxt inside {HDR, IMEM, DMEM_LO, DMEM_HI, CSUM};
      cpu_enable   <= (nxt == RUN);
      error        <= (nxt == ERROR);
      bus.imem_wen <= 1'b0;
      bus.dmem_wen <= 1'b0;
      if (fire) begin
        case (state)
          HDR: begin
            icnt <= IW'(hdr_i);
            dcnt <= DW'(hdr_d);
            i    <= '0;
            j    <= '0;
          end
          IMEM: begin
            bus.imem_wen   <= 1'b1;
            bus.imem_addr  <= 64'({i, 2'b00});
            bus.imem_wdata <= bus.s_data;
            i              <= i + IW'(1);
          end
          DMEM_LO: lo <= bus.s_data;
          DMEM_HI: begin
            bus.dmem_wen   <= 1'b1;
            bus.dmem_addr  <= 64'({j, 3'b000});
            bus.dmem_wdata <= {bus.s_data, lo};
            j              <= j + DW'(1);
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// Randomized frame bench for boot_loader; expected writes and outcome are
// derived from the frame contents, not from the loader's state machine.
module tb_boot_loader;
  localparam logic [31:0] MAGIC = 32'hB007_10AD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_enable, busy, error;
  int   vectors = 0;
  int   miscompares = 0;

  logic [63:0] got_ia[$], got_da[$], got_dd[$];
  logic [31:0] got_id[$];

  boot_loader_if bus ();

  boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.imem_wen) begin got_ia.push_back(bus.imem_addr); got_id.push_back(bus.imem_wdata); end
    if (bus.dmem_wen) begin got_da.push_back(bus.dmem_addr); got_dd.push_back(bus.dmem_wdata); end
  end

  task automatic clear_log();
    got_ia.delete(); got_id.delete(); got_da.delete(); got_dd.delete();
  endtask

  task automatic apply_reset();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_log();
  endtask

  // Optional random idle cycles (with junk data) before presenting the word.
  task automatic send_word(input logic [31:0] w, input int gap_pct);
    int g = 0;
    while (g < 4 && int'($urandom_range(0, 99)) < gap_pct) begin
      bus.s_valid = 1'b0;
      bus.s_data  = $urandom();
      @(negedge clk);
      g++;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.s_ready !== 1'b1 || bus.imem_wen !== 1'b0 || bus.dmem_wen !== 1'b0 ||
        cpu_enable !== 1'b0 || busy !== 1'b0 || error !== 1'b0 ||
        bus.imem_addr !== 64'd0 || bus.imem_wdata !== 32'd0 ||
        bus.dmem_addr !== 64'd0 || bus.dmem_wdata !== 64'd0) begin
      miscompares++;
      $display("FAIL reset: ready=%b wen=%b/%b en=%b busy=%b err=%b, expected ready=1 others 0",
               bus.s_ready, bus.imem_wen, bus.dmem_wen, cpu_enable, busy, error);
    end
    rst = 1'b0;
    clear_log();
  endtask

  task automatic test_load(input string name, input int ic, input int dc, input bit directed,
                           input bit corrupt, input int gap_pct, input bit garbage,
                           input bit abort_first);
    logic [31:0] pay[$];
    logic [63:0] eia[$], eda[$], edd[$];
    logic [31:0] eid[$];
    logic [31:0] hdr, csum;
    apply_reset();
    if (abort_first) begin
      send_word(MAGIC, 0);
      send_word(32'h0002_0001, 0);
      send_word(32'h0000_0013, 0);
      bus.s_valid = 1'b0;
      vectors++;
      if (busy !== 1'b1 || bus.imem_wen !== 1'b1) begin
        miscompares++;
        $display("FAIL %s pre_abort: busy=%b imem_wen=%b, expected 1/1", name, busy, bus.imem_wen);
      end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.s_ready !== 1'b1 || bus.imem_wen !== 1'b0 || bus.dmem_wen !== 1'b0 ||
          cpu_enable !== 1'b0 || busy !== 1'b0 || error !== 1'b0 ||
          bus.imem_addr !== 64'd0 || bus.imem_wdata !== 32'd0 ||
          bus.dmem_addr !== 64'd0 || bus.dmem_wdata !== 64'd0) begin
        miscompares++;
        $display("FAIL %s abort_reset: ready=%b wen=%b/%b en=%b busy=%b err=%b, expected ready=1 others 0",
                 name, bus.s_ready, bus.imem_wen, bus.dmem_wen, cpu_enable, busy, error);
      end
      rst = 1'b0;
      clear_log();
    end

    if (directed) begin
      pay.push_back(32'h0000_0013); pay.push_back(32'h0010_0093);
      pay.push_back(32'h1111_1111); pay.push_back(32'h2222_2222);
    end else begin
      for (int k = 0; k < ic + 2 * dc; k++) pay.push_back($urandom());
    end
    hdr  = {16'(ic), 16'(dc)};
    csum = hdr;
    foreach (pay[k]) csum ^= pay[k];
    if (corrupt) csum ^= 32'h0000_0100;
    for (int k = 0; k < ic; k++) begin eia.push_back(64'(4 * k)); eid.push_back(pay[k]); end
    for (int m = 0; m < dc; m++) begin
      eda.push_back(64'(8 * m));
      edd.push_back({pay[ic + 2 * m + 1], pay[ic + 2 * m]});
    end

    if (garbage) begin
      send_word(32'hDEAD_BEEF, gap_pct);
      send_word(32'h0000_0000, gap_pct);
    end
    send_word(MAGIC, gap_pct);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_after_magic: got %b expected 1", name, busy);
    end
    send_word(hdr, gap_pct);
    foreach (pay[k]) send_word(pay[k], gap_pct);
    vectors++;
    if (cpu_enable !== 1'b0 || error !== 1'b0 || bus.s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s before_csum: en=%b err=%b ready=%b expected 0/0/1",
               name, cpu_enable, error, bus.s_ready);
    end
    send_word(csum, gap_pct);
    vectors++;
    if ({cpu_enable, error, bus.s_ready, busy} !== {!corrupt, corrupt, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s after_csum: en/err/ready/busy=%b expected %b", name,
               {cpu_enable, error, bus.s_ready, busy}, {!corrupt, corrupt, 1'b0, 1'b0});
    end
    // Keep offering words: nothing more may be accepted or written.
    repeat (4) begin bus.s_data = $urandom(); @(negedge clk); end
    bus.s_valid = 1'b0;
    #1;
    vectors++;
    if (got_ia.size() != eia.size() || got_da.size() != eda.size()) begin
      miscompares++;
      $display("FAIL %s write_count: imem %0d dmem %0d expected %0d %0d",
               name, got_ia.size(), got_da.size(), eia.size(), eda.size());
    end
    for (int k = 0; k < eia.size() && k < got_ia.size(); k++) begin
      vectors++;
      if (got_ia[k] !== eia[k] || got_id[k] !== eid[k]) begin
        miscompares++;
        $display("FAIL %s imem[%0d]: addr %h data %h expected %h %h",
                 name, k, got_ia[k], got_id[k], eia[k], eid[k]);
      end
    end
    for (int m = 0; m < eda.size() && m < got_da.size(); m++) begin
      vectors++;
      if (got_da[m] !== eda[m] || got_dd[m] !== edd[m]) begin
        miscompares++;
        $display("FAIL %s dmem[%0d]: addr %h data %h expected %h %h",
                 name, m, got_da[m], got_dd[m], eda[m], edd[m]);
      end
    end
    vectors++;
    if (cpu_enable !== !corrupt || error !== corrupt) begin
      miscompares++;
      $display("FAIL %s final_status: en=%b err=%b expected %b %b",
               name, cpu_enable, error, !corrupt, corrupt);
    end
  endtask

  task automatic test_hdr_error(input string name, input logic [31:0] hdr);
    apply_reset();
    send_word(MAGIC, 0);
    send_word(hdr, 0);
    vectors++;
    if ({error, bus.s_ready, cpu_enable, busy} !== 4'b1000) begin
      miscompares++;
      $display("FAIL %s after_hdr: err/ready/en/busy=%b expected 1000", name,
               {error, bus.s_ready, cpu_enable, busy});
    end
    repeat (3) begin bus.s_data = $urandom(); @(negedge clk); end
    bus.s_valid = 1'b0;
    #1;
    vectors++;
    if (got_ia.size() + got_da.size() != 0 || error !== 1'b1 || cpu_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL %s no_writes: writes %0d err=%b en=%b expected 0 1 0", name,
               got_ia.size() + got_da.size(), error, cpu_enable);
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    test_reset();
    test_load("directed",   2, 1, 1'b1, 1'b0, 0,  1'b0, 1'b0);
    test_load("bad_csum",   2, 1, 1'b1, 1'b1, 0,  1'b0, 1'b0);
    test_load("garbage",    1, 0, 1'b0, 1'b0, 0,  1'b1, 1'b0);
    test_hdr_error("icount_513",  32'h0201_0000);
    test_hdr_error("dcount_1025", 32'h0000_0401);
    test_load("empty",      0, 0, 1'b0, 1'b0, 0,  1'b0, 1'b0);
    test_load("gaps",       2, 1, 1'b1, 1'b0, 40, 1'b0, 1'b0);
    test_load("mid_reset",  2, 1, 1'b1, 1'b0, 0,  1'b0, 1'b1);
    test_load("max_icount", 512, 1, 1'b0, 1'b0, 10, 1'b0, 1'b0);
    test_load("max_dcount", 0, 1024, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    repeat (6)
      test_load("random", int'($urandom_range(0, 12)), int'($urandom_range(0, 6)), 1'b0,
                ($urandom_range(0, 3) == 0), 30, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
